mux_sel_ctrl: RTL and testbench

- Synchronous controller directly upstream of the 1-of-2 FET mux model; drives the mux's s and notoe pins.
- Enforces break-before-make: output disabled (notoe=1) before s changes, held disabled for a guard time after.
- Supports auto-alternating channels on a fixed dwell or manual channel requests.
- Counts completed switch events for power/activity estimation.

---
 rtl/mux_sel_ctrl.sv | 134 +++++++++++++
 tb/tb_mux_sel_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux_sel_ctrl.sv
// Break-before-make select controller for a 1-of-2 FET mux.
// Drives s/notoe so s only moves while the mux is disconnected.
module mux_sel_ctrl #(
  parameter int DWELL = 8,
  parameter int GUARD = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             man_sel,
  output logic             s,
  output logic             notoe,
  output logic             busy,
  output logic             switch_done,
  output logic [CNT_W-1:0] sw_count
);

  localparam int GW = $clog2(GUARD + 1);
  localparam int DW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ON, DIS} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             stop_q, stop_d;
  logic             s_q, s_d;
  logic             notoe_q, notoe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             guardLast;
  logic             dwellLast;

  assign guardLast = (guard_q == GW'(GUARD - 1));
  assign dwellLast = (dwell_q >= DW'(DWELL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      guard_q <= '0;
      dwell_q <= '0;
      stop_q  <= 1'b0;
      s_q     <= 1'b0;
      notoe_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      dwell_q <= dwell_d;
      stop_q  <= stop_d;
      s_q     <= s_d;
      notoe_q <= notoe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // stop_q marks a DIS entered because enable dropped: it always runs the
  // full guard and then parks, whereas a switching DIS aborts on enable=0.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    dwell_d = dwell_q;
    stop_d  = stop_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          guard_d = '0;
          s_d     = mode ? 1'b0 : man_sel;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (guardLast) begin
          state_d = ON;
          dwell_d = '0;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      ON: begin
        if (!dwellLast) dwell_d = dwell_q + DW'(1);
        if (!enable) begin
          state_d = DIS;
          guard_d = '0;
          stop_d  = 1'b1;
        end else if ((mode && dwellLast) || (!mode && (man_sel != s_q))) begin
          state_d = DIS;
          guard_d = '0;
          stop_d  = 1'b0;
        end
      end
      DIS: begin
        if (stop_q) begin
          if (guardLast) state_d = IDLE;
          else           guard_d = guard_q + GW'(1);
        end else if (!enable) begin
          state_d = IDLE;
        end else if (guardLast) begin
          state_d = SETTLE;
          guard_d = '0;
          s_d     = mode ? ~s_q : man_sel;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    notoe_d = (state_d != ON);
    busy_d  = (state_d == SETTLE) || (state_d == DIS);
    done_d  = (state_q == SETTLE) && (state_d == ON);
    cnt_d   = cnt_q;
    if (done_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  assign s           = s_q;
  assign notoe       = notoe_q;
  assign busy        = busy_q;
  assign switch_done = done_q;
  assign sw_count    = cnt_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl: auto/manual switching, enable drops,
// async reset mid-sequence and counter saturation on a narrow instance.
module tb_mux_sel_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, mode, manSel;
  logic        s, notoe, busy, switchDone;
  logic [15:0] swCount;
  logic        enable2, mode2, manSel2;
  logic        s2, notoe2, busy2, switchDone2;
  logic [1:0]  swCount2;
  int          checks = 0;
  int          errors = 0;
  logic        sPrev, notoePrev;
  int          expCnt[5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  mux_sel_ctrl #(.DWELL(4), .GUARD(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .man_sel(manSel),
    .s(s), .notoe(notoe), .busy(busy), .switch_done(switchDone), .sw_count(swCount)
  );

  mux_sel_ctrl #(.DWELL(4), .GUARD(2), .CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .enable(enable2), .mode(mode2), .man_sel(manSel2),
    .s(s2), .notoe(notoe2), .busy(busy2), .switch_done(switchDone2), .sw_count(swCount2)
  );

  // s must only move while notoe was high on both sides of the change
  always @(negedge clk) begin
    if (!reset && (s !== sPrev)) begin
      checks++;
      assert (notoe === 1'b1 && notoePrev === 1'b1) else begin
        errors++;
        $error("[TB] FAIL bbm_invariant: observed notoe=%b/%b expected 1/1", notoePrev, notoe);
      end
    end
    sPrev     <= s;
    notoePrev <= notoe;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eS, input logic eN, input logic eB,
                          input logic eD, input int eC);
    checkOutput({tag, ".s"},     {31'd0, s},          {31'd0, eS});
    checkOutput({tag, ".notoe"}, {31'd0, notoe},      {31'd0, eN});
    checkOutput({tag, ".busy"},  {31'd0, busy},       {31'd0, eB});
    checkOutput({tag, ".done"},  {31'd0, switchDone}, {31'd0, eD});
    checkOutput({tag, ".cnt"},   {16'd0, swCount},    eC);
  endtask

  task automatic applyStimulus(input logic en, input logic md, input logic ms);
    enable = en;
    mode   = md;
    manSel = ms;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    enable2 = 1'b0; mode2 = 1'b0; manSel2 = 1'b0;
    #12;
    checkAll("rst", 0, 1, 0, 0, 0);
    reset = 1'b0;

    // auto mode: 2 SETTLE, 4 ON, 2 DIS, 2 SETTLE, period 8
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();  checkAll("auto_set0", 0, 1, 1, 0, 0);
    tick();  checkAll("auto_set1", 0, 1, 1, 0, 0);
    tick();  checkAll("auto_on0", 0, 0, 0, 1, 1);
    tick(3); checkAll("auto_on3", 0, 0, 0, 0, 1);
    tick();  checkAll("auto_dis0", 0, 1, 1, 0, 1);
    tick(2); checkAll("auto_set_s1", 1, 1, 1, 0, 1);
    tick(2); checkAll("auto_on_s1", 1, 0, 0, 1, 2);
    tick(7); checkAll("auto_pre3", 0, 1, 1, 0, 2);
    tick();  checkAll("auto_on3rd", 0, 0, 0, 1, 3);

    // manual mode: hold, then request channel 1
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(3); checkAll("man_hold", 0, 0, 0, 0, 3);
    manSel = 1'b1;
    tick();  checkAll("man_dis0", 0, 1, 1, 0, 3);
    tick();  checkAll("man_dis1", 0, 1, 1, 0, 3);
    tick();  checkAll("man_set0", 1, 1, 1, 0, 3);
    tick();  checkAll("man_set1", 1, 1, 1, 0, 3);
    tick();  checkAll("man_on", 1, 0, 0, 1, 4);

    // enable drop while ON: full guard, then park with s kept
    enable = 1'b0;
    tick();  checkAll("stop_dis0", 1, 1, 1, 0, 4);
    tick();  checkAll("stop_dis1", 1, 1, 1, 0, 4);
    tick();  checkAll("stop_idle", 1, 1, 0, 0, 4);

    // enable drop during SETTLE
    enable = 1'b1;
    tick();  checkAll("sabort_set", 1, 1, 1, 0, 4);
    enable = 1'b0;
    tick();  checkAll("sabort_idle", 1, 1, 0, 0, 4);
    tick();  checkAll("sabort_hold", 1, 1, 0, 0, 4);

    // async reset during DIS
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();  checkAll("r1_set", 0, 1, 1, 0, 4);
    tick(2); checkAll("r1_on", 0, 0, 0, 1, 5);
    tick(4); checkAll("r1_dis", 0, 1, 1, 0, 5);
    #2 reset = 1'b1;
    #1 checkAll("r1_async", 0, 1, 0, 0, 0);
    #4 reset = 1'b0;
    tick();  checkAll("r1_restart", 0, 1, 1, 0, 0);
    tick(2); checkAll("r1_on_again", 0, 0, 0, 1, 1);

    // async reset during ON
    #2 reset = 1'b1;
    #1 checkAll("r2_async", 0, 1, 0, 0, 0);
    #4 reset = 1'b0;
    tick(3); checkAll("r2_on_again", 0, 0, 0, 1, 1);

    // man_sel bounces 0->1->0 inside DIS: exit reloads s=0, still counts
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();  checkAll("bounce_hold", 0, 0, 0, 0, 1);
    manSel = 1'b1;
    tick();  checkAll("bounce_dis0", 0, 1, 1, 0, 1);
    manSel = 1'b0;
    tick();  checkAll("bounce_dis1", 0, 1, 1, 0, 1);
    tick();  checkAll("bounce_set", 0, 1, 1, 0, 1);
    tick(2); checkAll("bounce_on", 0, 0, 0, 1, 2);

    // enable drop inside a switching DIS parks on the next edge
    manSel = 1'b1;
    tick();  checkAll("swabort_dis", 0, 1, 1, 0, 2);
    enable = 1'b0;
    tick();  checkAll("swabort_idle", 0, 1, 0, 0, 2);

    // narrow counter saturates at 3 while pulses continue
    enable2 = 1'b1; mode2 = 1'b1;
    tick(3);
    checkOutput("sat_done0", {31'd0, switchDone2}, 32'd1);
    checkOutput("sat_cnt0", {30'd0, swCount2}, expCnt[0]);
    for (int k = 1; k < 5; k++) begin
      tick(7);
      checkOutput($sformatf("sat_gap%0d", k), {31'd0, switchDone2}, 32'd0);
      tick();
      checkOutput($sformatf("sat_done%0d", k), {31'd0, switchDone2}, 32'd1);
      checkOutput($sformatf("sat_cnt%0d", k), {30'd0, swCount2}, expCnt[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
